// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hardwired ALU control sequencer.
// Covers step states, opcode values, IR field positions and opcode classification.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    StRst,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StHalt
  } state_e;

  typedef enum logic [1:0] {
    ClsBinary,
    ClsUnary,
    ClsHalt,
    ClsIllegal
  } op_class_e;

  localparam int unsigned OpFieldW  = 5;
  localparam int unsigned RegFieldW = 4;

  localparam int unsigned OpLsb = 27;
  localparam int unsigned RaLsb = 23;
  localparam int unsigned RbLsb = 19;
  localparam int unsigned RcLsb = 15;

  localparam logic [OpFieldW-1:0] OpAdd  = 5'b00011;
  localparam logic [OpFieldW-1:0] OpSub  = 5'b00100;
  localparam logic [OpFieldW-1:0] OpAnd  = 5'b00101;
  localparam logic [OpFieldW-1:0] OpOr   = 5'b00110;
  localparam logic [OpFieldW-1:0] OpShr  = 5'b00111;
  localparam logic [OpFieldW-1:0] OpShra = 5'b01000;
  localparam logic [OpFieldW-1:0] OpShl  = 5'b01001;
  localparam logic [OpFieldW-1:0] OpRor  = 5'b01010;
  localparam logic [OpFieldW-1:0] OpRol  = 5'b01011;
  localparam logic [OpFieldW-1:0] OpMul  = 5'b01111;
  localparam logic [OpFieldW-1:0] OpDiv  = 5'b10000;
  localparam logic [OpFieldW-1:0] OpNeg  = 5'b10001;
  localparam logic [OpFieldW-1:0] OpNot  = 5'b10010;
  localparam logic [OpFieldW-1:0] OpHalt = 5'b11011;

  function automatic op_class_e op_class(input logic [OpFieldW-1:0] op);
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShra, OpShl, OpRor, OpRol, OpMul, OpDiv:
        op_class = ClsBinary;
      OpNeg, OpNot: op_class = ClsUnary;
      OpHalt:       op_class = ClsHalt;
      default:      op_class = ClsIllegal;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Turns the Ra/Rb/Rc register fields into one-hot load and bus-drive enables.
// Rout drives either Rb or Rc; Rin always targets Ra.
module reg_select_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [RegFieldW-1:0] ra_i,
  input  logic [RegFieldW-1:0] rb_i,
  input  logic [RegFieldW-1:0] rc_i,
  input  logic                 rout_sel_rc_i,
  input  logic                 rin_en_i,
  input  logic                 rout_en_i,
  output logic [NUM_REGS-1:0]  rin_o,
  output logic [NUM_REGS-1:0]  rout_o
);

  logic [RegFieldW-1:0] rout_idx;

  assign rout_idx = rout_sel_rc_i ? rc_i : rb_i;
  assign rin_o    = rin_en_i  ? (NUM_REGS'(1) << ra_i)     : '0;
  assign rout_o   = rout_en_i ? (NUM_REGS'(1) << rout_idx) : '0;

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/execute step sequencer for register-format ALU instructions.
// Strobes are decoded combinationally from the step register, IR and Stall.
module alu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned OP_W     = 5
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [31:0]         IR,
  input  logic                Stall,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zin,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zlowout,
  output logic                ZHighout,
  output logic                LOin,
  output logic                HIin,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OP_W-1:0]     operation,
  output logic                Run,
  output logic                Illegal
);

  state_e                state_q, state_d;
  logic [OpFieldW-1:0]   opcode;
  op_class_e             op_cls;
  logic                  is_muldiv;
  logic                  rin_en, rout_en, rout_sel_rc;
  logic                  unused_ir;

  assign opcode    = IR[OpLsb +: OpFieldW];
  assign op_cls    = op_class(opcode);
  assign is_muldiv = (opcode == OpMul) || (opcode == OpDiv);
  assign unused_ir = ^IR[RcLsb-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:  state_d = StT0;
      StHalt: state_d = StHalt;
      StT0:   if (!Stall) state_d = StT1;
      StT1:   if (!Stall) state_d = StT2;
      StT2:   if (!Stall) state_d = StT3;
      StT3: begin
        if (!Stall) begin
          unique case (op_cls)
            ClsHalt:    state_d = StHalt;
            ClsIllegal: state_d = StT0;
            default:    state_d = StT4;
          endcase
        end
      end
      StT4:   if (!Stall) state_d = StT5;
      StT5:   if (!Stall) state_d = is_muldiv ? StT6 : StT0;
      StT6:   if (!Stall) state_d = StT0;
      default: state_d = StRst;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    PCout       = 1'b0;
    MARin       = 1'b0;
    IncPC       = 1'b0;
    Zin         = 1'b0;
    PCin        = 1'b0;
    Read        = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zlowout     = 1'b0;
    ZHighout    = 1'b0;
    LOin        = 1'b0;
    HIin        = 1'b0;
    operation   = '0;
    Run         = 1'b0;
    Illegal     = 1'b0;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rout_sel_rc = 1'b0;
    // A stalled step is a bubble: nothing at all is driven for that cycle.
    if (!Stall) begin
      unique case (state_q)
        StT0: begin
          Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        end
        StT1: begin
          Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        end
        StT2: begin
          Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        end
        StT3: begin
          Run     = 1'b1;
          Yin     = (op_cls == ClsBinary) || (op_cls == ClsUnary);
          rout_en = (op_cls == ClsBinary);
          Illegal = (op_cls == ClsIllegal);
        end
        StT4: begin
          Run         = 1'b1;
          Zin         = 1'b1;
          rout_en     = 1'b1;
          rout_sel_rc = (op_cls == ClsBinary);
          operation   = OP_W'(opcode);
        end
        StT5: begin
          Run     = 1'b1;
          Zlowout = 1'b1;
          LOin    = is_muldiv;
          rin_en  = !is_muldiv;
        end
        StT6: begin
          Run = 1'b1; ZHighout = 1'b1; HIin = 1'b1;
        end
        default: ;
      endcase
    end
  end

  reg_select_decoder #(
    .NUM_REGS(NUM_REGS)
  ) u_reg_select_decoder (
    .ra_i         (IR[RaLsb +: RegFieldW]),
    .rb_i         (IR[RbLsb +: RegFieldW]),
    .rc_i         (IR[RcLsb +: RegFieldW]),
    .rout_sel_rc_i(rout_sel_rc),
    .rin_en_i     (rin_en),
    .rout_en_i    (rout_en),
    .rin_o        (Rin),
    .rout_o       (Rout)
  );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Self-checking bench: directed and random instructions against a per-cycle
// expected-strobe list built from the instruction's class.
module tb_alu_control_sequencer;

  typedef struct packed {
    logic        pcout, marin, incpc, zin, pcin, read, mdrin, mdrout, irin, yin;
    logic        zlowout, zhighout, loin, hiin;
    logic [15:0] rin, rout;
    logic [4:0]  op;
    logic        run, illegal;
  } obs_t;

  logic        Clock, Reset_n, Stall;
  logic [31:0] IR;
  logic        PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic        Zlowout, ZHighout, LOin, HIin, Run, Illegal;
  logic [15:0] Rin, Rout;
  logic [4:0]  operation;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];
  obs_t zero = '0;

  alu_control_sequencer #(.NUM_REGS(16), .OP_W(5)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Stall(Stall),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowout(Zlowout),
    .ZHighout(ZHighout), .LOin(LOin), .HIin(HIin), .Rin(Rin), .Rout(Rout),
    .operation(operation), .Run(Run), .Illegal(Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic obs_t sample();
    return {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
            Zlowout, ZHighout, LOin, HIin, Rin, Rout, operation, Run, Illegal};
  endfunction

  task automatic check(input string tag, input obs_t exp);
    obs_t got;
    got = sample();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Expected step list for one instruction, starting at the first fetch step.
  function automatic void build(input logic [31:0] ir);
    obs_t e;
    int   op, ra, rb, rc;
    bit   binary, unary, muldiv;
    op = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    binary = (op >= 3 && op <= 11) || op == 15 || op == 16;
    unary  = op == 17 || op == 18;
    muldiv = op == 15 || op == 16;
    exp_q.delete();
    e = '0; e.run = 1; e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1; exp_q.push_back(e);
    e = '0; e.run = 1; e.zlowout = 1; e.pcin = 1; e.read = 1; e.mdrin = 1; exp_q.push_back(e);
    e = '0; e.run = 1; e.mdrout = 1; e.irin = 1; exp_q.push_back(e);
    e = '0; e.run = 1;
    if (!binary && !unary) begin
      e.illegal = (op != 27);
      exp_q.push_back(e);
      return;
    end
    e.yin = 1;
    if (binary) e.rout = 16'(1) << rb;
    exp_q.push_back(e);
    e = '0; e.run = 1; e.zin = 1; e.op = 5'(op);
    e.rout = 16'(1) << (binary ? rc : rb);
    exp_q.push_back(e);
    e = '0; e.run = 1; e.zlowout = 1;
    if (muldiv) e.loin = 1; else e.rin = 16'(1) << ra;
    exp_q.push_back(e);
    if (muldiv) begin
      e = '0; e.run = 1; e.zhighout = 1; e.hiin = 1; exp_q.push_back(e);
    end
  endfunction

  task automatic do_reset(input string tag);
    Reset_n = 1'b0;
    Stall = 1'($urandom_range(1));
    #1 check({tag, "_rst_low"}, zero);
    tick();
    check({tag, "_rst_hold"}, zero);
    Reset_n = 1'b1;
    Stall = 1'b0;
    #1 check({tag, "_rst_srst"}, zero);
    tick();
  endtask

  // Entered at posedge+1 with the sequencer in the first fetch step.
  task automatic run_instr(input string tag, input logic [31:0] ir, input int stall_pct,
                           input int stall_step, input int stall_cnt, input int abort_at);
    int nst;
    IR = ir;
    build(ir);
    foreach (exp_q[i]) begin
      nst = (i == stall_step) ? stall_cnt : 0;
      while (nst < 3 && stall_pct > 0 && int'($urandom_range(99)) < stall_pct) nst++;
      for (int s = 0; s < nst; s++) begin
        Stall = 1'b1;
        #1 check($sformatf("%s_stall_s%0d", tag, i), zero);
        tick();
      end
      Stall = 1'b0;
      #1 check($sformatf("%s_s%0d", tag, i), exp_q[i]);
      if (i == abort_at) begin
        do_reset({tag, "_abort"});
        return;
      end
      tick();
    end
    if (ir[31:27] == 5'b11011) begin
      for (int c = 0; c < 22; c++) begin
        Stall = 1'($urandom_range(1));
        #1 check($sformatf("%s_halted_c%0d", tag, c), zero);
        tick();
      end
      do_reset({tag, "_halt"});
    end
  endtask

  initial begin
    logic [31:0] ir;
    logic [4:0]  op;
    Reset_n = 1'b0;
    Stall   = 1'b0;
    IR      = '0;
    #2 check("reset_state", zero);
    tick();
    do_reset("init");

    run_instr("or",     32'h321B8000, 0, -1, 0, -1);
    run_instr("mul",    32'h781B8000, 0, -1, 0, -1);
    run_instr("undef",  32'hF8000000, 0, -1, 0, -1);
    run_instr("stall",  32'h1A2B3000, 0,  1, 2, -1);
    run_instr("div",    32'h80C48000, 0, -1, 0, -1);
    run_instr("neg",    32'h8A988000, 0, -1, 0, -1);
    run_instr("same",   32'h1C438000, 0, -1, 0, -1);
    run_instr("abort",  32'h1A2B3000, 0, -1, 0,  4);
    run_instr("after",  32'h4FFF8000, 0, -1, 0, -1);
    run_instr("halt",   32'hD8000000, 0, -1, 0, -1);

    for (int n = 0; n < 60; n++) begin
      ir = $urandom();
      case ($urandom_range(9))
        0, 1:    op = 5'($urandom_range(31));
        2:       op = 5'($urandom_range(15, 16));
        3:       op = 5'($urandom_range(17, 18));
        default: op = 5'($urandom_range(3, 11));
      endcase
      ir[31:27] = op;
      run_instr($sformatf("rnd%0d", n), ir, 20, -1, 0,
                ($urandom_range(19) == 0) ? int'($urandom_range(6)) : -1);
    end
    run_instr("final", 32'hD8000000, 0, -1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end

endmodule
